// File: rtl/xform_arbiter.sv
// rtl/xform_arbiter.sv - round-robin arbiter sharing one byte transform unit
// Tracks the unit's one-cycle latency with a tag and returns tagged results via a credited FIFO.
module xform_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int IDW        = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           xf_in,
   input  logic [7:0]           xf_out,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_data,
   output logic [IDW-1:0]       rsp_id,
   input  logic                 rsp_ready,
   output logic                 busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] pend_id;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] cand;
   logic           pending;
   logic           issue_ok;
   logic           transfer;
   logic [CW-1:0]  count;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [7:0]     mem_data [FIFO_DEPTH];
   logic [IDW-1:0] mem_id   [FIFO_DEPTH];
   logic           push;
   logic           pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // The in-flight result already holds a FIFO slot, so it counts against credit.
   assign issue_ok = !rst && en && ((int'(count) + int'(pending)) < FIFO_DEPTH);

   always_comb begin
      req_ready = '0;
      xf_in     = 8'h00;
      gnt_idx   = '0;
      transfer  = 1'b0;
      cand      = ptr;
      if (issue_ok) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + IDW'(1);
            if (!transfer && req_valid[cand]) begin
               transfer = 1'b1;
               gnt_idx  = cand;
            end
         end
      end
      if (transfer) begin
         req_ready[gnt_idx] = 1'b1;
         xf_in              = req_data[{gnt_idx, 3'b000} +: 8];
      end
   end

   assign push      = pending;
   assign rsp_valid = (count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_data  = mem_data[rd_ptr];
   assign rsp_id    = mem_id[rd_ptr];
   assign busy      = pending || (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= IDW'(NUM_REQ - 1);
         pending <= 1'b0;
         pend_id <= '0;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= 8'h00;
            mem_id[i]   <= '0;
         end
      end else begin
         pending <= transfer;
         if (transfer) begin
            ptr     <= gnt_idx;
            pend_id <= gnt_idx;
         end
         if (push) begin
            mem_data[wr_ptr] <= xf_out;
            mem_id[wr_ptr]   <= pend_id;
            wr_ptr           <= wrap_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= wrap_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/xform_arbiter.md
# xform_arbiter

Round-robin arbiter and sequencer that shares one byte transform unit between NUM_REQ requesters. It issues at most one accepted byte per cycle into the transform unit and tracks the unit's one-cycle registered latency with an in-flight tag. Results return on a single tagged response channel through a credit-protected output FIFO. The block sits between the requester ports and the transform datapath and owns the transform unit's input bus.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- FIFO_DEPTH, 4, response FIFO entries (≥2)
- IDW, $clog2(NUM_REQ), response tag width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; also drives the transform unit's reset
- en  in  1  grant enable; low blocks new grants, in-flight work still drains
- req_valid  in  NUM_REQ  per-requester valid
- req_data  in  8*NUM_REQ  per-requester byte, requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- xf_in  out  8  byte to transform unit input
- xf_out  in  8  transform unit registered output
- rsp_valid  out  1  FIFO head valid
- rsp_data  out  8  transformed byte
- rsp_id  out  IDW  index of originating requester
- rsp_ready  in  1  consumer accepts head
- busy  out  1  high when pending or FIFO count ≠ 0

## Operation
- Credit: `issue_ok = en && (count + pending < FIFO_DEPTH)`. Use current-cycle count. A same-cycle pop does not add credit.
- Arbitration: when issue_ok, grant the first requester with valid set, searching upward from ptr+1 modulo NUM_REQ. `req_ready` is one-hot on that index and zero when no grant is made. It depends combinationally on req_valid, ptr, count, pending and en.
- Transfer occurs when `req_valid[g] && req_ready[g]`. On a transfer, ptr ← g.
- xf_in = req_data of granted index during a transfer cycle, else 8'h00.
- Tag pipeline:
  - on a transfer, pending ← 1 and pend_id ← g; otherwise pending ← 0.
- When pending is high, write {pend_id, xf_out} into the FIFO that cycle. xf_out is ignored when pending is low.
- FIFO:
  - depth FIFO_DEPTH, registered, not fall-through.
  - Head is presented on rsp_*.
  - Pop on `rsp_valid && rsp_ready`.
  - Simultaneous push and pop are allowed at any count, with count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow is impossible by the credit rule. The verifier asserts that a push never occurs when count == FIFO_DEPTH.
- rsp_valid = (count != 0). rsp_data and rsp_id are don't-care when rsp_valid is low but must not be X after reset.
- Transform reference values for checking, with 8-bit truncation:
  - FF→FE, F9→08, E5→D5, A5→94, 85→63, 50→1D, 10→CC, 00→00.

## Timing
- Reset (synchronous, rst=1 at a rising edge):
  - ptr ← NUM_REQ-1, so requester 0 has first priority.
  - pending ← 0, count ← 0, FIFO pointers ← 0.
- Outputs during and after reset:
  - req_ready = 0 while rst is high.
  - rsp_valid = 0, rsp_data = 8'h00, rsp_id = 0, busy = 0, xf_in = 8'h00.
- Latency: a transfer in cycle t gives xf_out valid in t+1, FIFO push at the end of t+1, and rsp_valid in t+2 at the earliest.
- Throughput: one transfer per cycle sustained while rsp_ready=1 and FIFO_DEPTH ≥ 2.
- Backpressure: with rsp_ready=0, at most FIFO_DEPTH transfers complete, then req_ready stays 0. One credit returns the cycle after each pop.
- en deassert: no grant in that same cycle. A pending result is still pushed next cycle.
- Reset mid-operation: the in-flight result and all FIFO contents are discarded, and no response is emitted for them.
- Request with no grant: req_data may change freely. The requester must hold valid until granted (not checked).

## Test plan
- Single request: req 0 sends 8'hF9 in cycle 1 → rsp_valid in cycle 3 with rsp_data=8'h08, rsp_id=0; busy high for cycles 2–3.
- Round-robin fairness: all 4 valid continuously, rsp_ready=1, 8 cycles → grants 0,1,2,3,0,1,2,3, one per cycle, with rsp_id in the same order.
- Full sweep: req 2 sends FF, E5, A5, 85, 50, 10, 00 back-to-back → rsp_data FE, D5, 94, 63, 1D, CC, 00 in order, all with rsp_id=2.
- Backpressure: rsp_ready=0, req 1 valid continuously → exactly 4 transfers, then req_ready=0. Raise rsp_ready for one cycle → exactly one further transfer one cycle later; no loss, order preserved.
- en low: requests pending, en=0 → no grants. An in-flight byte still appears on rsp. Set en=1 → grant resumes from ptr+1.
- Reset mid-stream: FIFO holding 3 entries plus one pending; assert rst one cycle → rsp_valid=0, busy=0, next grant goes to requester 0, and no stale data is emitted.
